memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares the single RAM port between the two instruction caches and the data-side port of the coherence controller in the dual-core system. Grants one requester at a time, holds the grant until the RAM reports ACCESS, and keeps the RAM locked to the data side for multi-word coherence sequences. Arbitration uses data-first priority, with a starvation guard and round-robin between the two instruction ports.

## Interface

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request waits before one instruction grant is forced.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  2  instruction read request, per core.
- iaddr  in  2x32  instruction word address, per core.
- iwait  out  2  instruction wait, per core; 0 for exactly the completing cycle.
- iload  out  2x32  instruction data, per core.
- dREN  in  1  data read request from coherence controller.
- dWEN  in  1  data write request from coherence controller.
- daddr  in  32  data word address.
- dstore  in  32  data write word.
- dlock  in  1  coherence controller is mid-sequence; keep the RAM granted to the data side.
- dwait  out  1  data wait; 0 for exactly the completing cycle.
- dload  out  32  data read word.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address and write word.
- ramload  in  32  RAM read word.
- ramstate  in  ramstate_t  FREE / BUSY / ACCESS / ERROR (cpu_types_pkg).

## Operation

- **States:** IDLE, DGRANT, IGRANT. Registers: state, igrant index `ig` (1 bit), round-robin pointer `rr` (1 bit), starve counter `sc` (3 bits, saturating at STARVE_LIMIT).
- **IDLE:** drives no RAM strobes and holds all waits at 1. Selects the next state as follows:
  - A data request (dREN|dWEN) is pending, and either no instruction request is pending or sc < STARVE_LIMIT → DGRANT.
  - Otherwise, any iREN is pending → IGRANT. Set ig = rr if iREN[rr] is high, else the other index.
  - Otherwise, stay in IDLE.
- **DGRANT:** ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore, dload=ramload, dwait = (ramstate != ACCESS).
  - dREN and dWEN both high: write wins. ramREN is forced to 0.
  - On ACCESS with dlock=1 → stay in DGRANT.
  - On ACCESS with dlock=0 → IDLE.
  - If dREN=dWEN=0 and dlock=0 → IDLE, with no strobes that cycle.
- **IGRANT:** ramREN=1, ramaddr=iaddr[ig], iload[ig]=ramload, iwait[ig] = (ramstate != ACCESS).
  - On ACCESS → IDLE, with rr = ~ig.
  - If iREN[ig] drops before ACCESS → IDLE with no strobe that cycle; rr is unchanged.
- **Starve counter:**
  - On each DGRANT completion (ACCESS) while any iREN is high, sc increments, saturating.
  - sc clears on any IGRANT completion, or when no iREN is high in IDLE.
- **ERROR ramstate:** treated as BUSY. The grant is held and wait stays 1, so the request retries.
- **Ungranted requesters:** wait=1 and load=0 at all times.

## Timing

- **Reset (async):** state=IDLE, rr=0, ig=0, sc=0. Outputs: iwait=2'b11, dwait=1, iload=0, dload=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- **Latency:** request seen in IDLE at cycle N → grant state at N+1 with the RAM strobe driven combinationally. wait falls in the first cycle ramstate==ACCESS, which is N+1 at the earliest. Minimum is 2 cycles from request to completion.
- **Return to IDLE:** after a completion, the arbiter always spends one cycle in IDLE, except under dlock, where back-to-back data words complete on consecutive ACCESS cycles with no bubble.
- **dlock:** sampled only on completion cycles. dlock=1 in IDLE with no dREN/dWEN has no effect.
- **Simultaneous iREN[0] and iREN[1]:** granted alternately per rr.
- **Request changes:** a requester that changes address mid-grant is not re-arbitrated. The RAM sees the new address immediately.
- **Reset mid-grant:** strobes drop asynchronously and the in-flight access is abandoned.

## Test plan

- **Reset and single fetch:** assert nRST=0 mid-IGRANT → all waits 1 and strobes 0 immediately. Then iREN=01, iaddr[0]=0x100, RAM latency 2 → ramaddr=0x100 held, iwait[0]=0 for one cycle, iload[0]=ramload.
- **Dual fetch fairness:** iREN=11 held for 4 fetches → grant order core0, core1, core0, core1, one IDLE cycle between each.
- **Data priority and starvation:** dREN held continuously, dlock=0, iREN=01 → 4 data completions, then one core0 completion, then data resumes. sc=0 after the instruction grant.
- **Locked pair:** dWEN, dlock=1, daddr=0x200 then 0x204, dstore=0xDEAD/0xBEEF, with iREN=11 pending → two consecutive ramWEN accesses with no IGRANT between them. IDLE follows after dlock=0.
- **Withdrawal and ERROR:** iREN[1] dropped while ramstate=BUSY → ramREN=0 the next cycle and rr unchanged. dREN with ramstate=ERROR for 3 cycles then ACCESS → dwait stays 1 through the ERROR cycles, then pulses 0 once.
- **Read/write conflict:** dREN=dWEN=1 → ramWEN=1, ramREN=0, ramstore=dstore.

Source files
------------

// File: rtl/memory_arbiter.sv
// RAM port arbiter for two instruction caches and the coherence data port.
// Data-first priority with a starvation guard, round-robin between cores, and dlock for multi-word sequences.
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dstore,
  input  logic             dlock,
  output logic             dwait,
  output logic [31:0]      dload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  ramstate_t        ramstate
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  localparam logic [2:0] SC_MAX = 3'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic       ig_q, ig_d;
  logic       rr_q, rr_d;
  logic [2:0] sc_q, sc_d;

  logic dreq, ireq, access;

  assign dreq   = dREN | dWEN;
  assign ireq   = |iREN;
  assign access = (ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ig_q    <= 1'b0;
      rr_q    <= 1'b0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      ig_q    <= ig_d;
      rr_q    <= rr_d;
      sc_q    <= sc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ig_d     = ig_q;
    rr_d     = rr_q;
    sc_d     = sc_q;
    iwait    = '1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    unique case (state_q)
      IDLE: begin
        if (!ireq) sc_d = '0;
        if (dreq && (!ireq || sc_q < SC_MAX)) begin
          state_d = DGRANT;
        end else if (ireq) begin
          state_d = IGRANT;
          ig_d    = iREN[rr_q] ? rr_q : ~rr_q;
        end
      end

      DGRANT: begin
        // A simultaneous read and write resolves to the write.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = ~access;
        if (access) begin
          if (ireq && sc_q < SC_MAX) sc_d = sc_q + 3'd1;
          if (!dlock) state_d = IDLE;
        end else if (!dreq && !dlock) begin
          state_d = IDLE;
        end
      end

      IGRANT: begin
        ramaddr     = iaddr[ig_q];
        iload[ig_q] = ramload;
        if (!iREN[ig_q]) begin
          state_d = IDLE;
        end else begin
          ramREN      = 1'b1;
          iwait[ig_q] = ~access;
          if (access) begin
            state_d = IDLE;
            rr_d    = ~ig_q;
            sc_d    = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a latency/ERROR-injecting RAM model and per-scenario tasks.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
  } ev_t;

  logic             CLK;
  logic             nRST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic             dREN, dWEN, dlock, dwait;
  logic [31:0]      daddr, dstore, dload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  ramstate_t        ramstate;

  int unsigned tests_run = 0;
  int unsigned fails     = 0;
  int unsigned cyc       = 0;
  bit          mon_en    = 0;
  ev_t         exp_q[$];
  ev_t         got_q[$];

  int unsigned ram_lat = 2;
  int unsigned rcnt    = 0;
  int unsigned err_n   = 0;
  int unsigned err_tag = 0;
  int unsigned err_tag_seen = 0;
  int unsigned err_seen = 0;

  memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dlock(dlock),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic ev_t mk_ev(input logic [1:0] who, input logic [31:0] addr,
                                input logic [31:0] data, input logic we);
    ev_t e;
    e.who = who; e.addr = addr; e.data = data; e.we = we;
    return e;
  endfunction

  // RAM model: ERROR for err_n strobed cycles after err_tag changes, then BUSY until ram_lat.
  always_comb begin
    if (!(ramREN | ramWEN))      ramstate = FREE;
    else if (err_seen < err_n)   ramstate = ERROR;
    else if (rcnt + 1 >= ram_lat) ramstate = ACCESS;
    else                         ramstate = BUSY;
    ramload = (ramstate == ACCESS) ? pat(ramaddr) : 32'hBAD0_BAD0;
  end

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rcnt <= 0;
    end else begin
      if (!(ramREN | ramWEN) || ramstate == ACCESS) rcnt <= 0;
      else if (ramstate == BUSY)                    rcnt <= rcnt + 1;
      if (err_tag != err_tag_seen) begin
        err_tag_seen <= err_tag;
        err_seen     <= 0;
      end else if ((ramREN | ramWEN) && err_seen < err_n) begin
        err_seen <= err_seen + 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      ev_t e;
      got_q.delete();
      for (int k = 0; k < 2; k++)
        if (iwait[k] === 1'b0) got_q.push_back(mk_ev(2'(k), ramaddr, iload[k], 1'b0));
      if (dwait === 1'b0)
        got_q.push_back(mk_ev(2'd2, ramaddr, ramWEN ? ramstore : dload, ramWEN));
      foreach (got_q[j]) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_unexpected: got who=%0d addr=%h data=%h we=%0b, required no completion",
                   got_q[j].who, got_q[j].addr, got_q[j].data, got_q[j].we);
        end else begin
          e = exp_q.pop_front();
          if (got_q[j] !== e) begin
            fails++;
            $display("FAIL scoreboard: got who=%0d addr=%h data=%h we=%0b, required who=%0d addr=%h data=%h we=%0b",
                     got_q[j].who, got_q[j].addr, got_q[j].data, got_q[j].we, e.who, e.addr, e.data, e.we);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic wait_done(input int unsigned maxc, output int unsigned c, output bit ok);
    ok = 0;
    c  = 0;
    for (int unsigned i = 0; i < maxc; i++) begin
      @(negedge CLK);
      if (iwait !== 2'b11 || dwait !== 1'b1) begin
        ok = 1;
        c  = cyc;
        return;
      end
    end
  endtask

  task automatic do_reset();
    mon_en = 0;
    nRST = 1'b0;
    iREN = '0; iaddr = '0;
    dREN = 1'b0; dWEN = 1'b0; dlock = 1'b0; daddr = '0; dstore = '0;
    ram_lat = 2; err_n = 0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    mon_en = 1;
  endtask

  task automatic test_reset();
    do_reset();
    ram_lat = 10;
    iaddr[0] = 32'h100;
    iREN = 2'b01;
    @(posedge CLK); #1;
    tests_run++;
    if (ramREN !== 1'b1) begin
      fails++; $display("FAIL reset_pre_grant: ramREN=%b, required 1", ramREN);
    end
    #2 nRST = 1'b0;
    #1;
    tests_run++;
    if ({iwait, dwait, ramREN, ramWEN} !== 5'b11100) begin
      fails++; $display("FAIL reset_strobes: {iwait,dwait,ramREN,ramWEN}=%b, required 11100",
                        {iwait, dwait, ramREN, ramWEN});
    end
    tests_run++;
    if (iload !== '0 || dload !== '0 || ramaddr !== '0 || ramstore !== '0) begin
      fails++; $display("FAIL reset_buses: iload=%h dload=%h ramaddr=%h ramstore=%h, required all 0",
                        iload, dload, ramaddr, ramstore);
    end
    iREN = '0;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    iaddr[0] = 32'h100;
    iREN = 2'b01;
    exp_q.push_back(mk_ev(2'd0, 32'h100, pat(32'h100), 1'b0));
    @(posedge CLK); #1;
    tests_run++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h100 || iwait !== 2'b11) begin
      fails++; $display("FAIL single_grant: ramREN=%b ramaddr=%h iwait=%b, required 1 00000100 11",
                        ramREN, ramaddr, iwait);
    end
    @(posedge CLK); #1;
    tests_run++;
    if (iwait !== 2'b10 || iload[0] !== pat(32'h100) || iload[1] !== '0) begin
      fails++; $display("FAIL single_complete: iwait=%b iload0=%h iload1=%h, required 10 %h 0",
                        iwait, iload[0], iload[1], pat(32'h100));
    end
    @(posedge CLK); #1;
    iREN = '0;
    tests_run++;
    if (iwait !== 2'b11 || ramREN !== 1'b0) begin
      fails++; $display("FAIL single_idle: iwait=%b ramREN=%b, required 11 0", iwait, ramREN);
    end
    repeat (2) @(posedge CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL single_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_fairness();
    int unsigned c, prev;
    bit ok;
    do_reset();
    iaddr[0] = 32'h10; iaddr[1] = 32'h20;
    iREN = 2'b11;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(mk_ev(2'(i % 2), (i % 2) ? 32'h20 : 32'h10, pat((i % 2) ? 32'h20 : 32'h10), 1'b0));
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_done(20, c, ok);
      tests_run++;
      if (!ok) begin
        fails++; $display("FAIL fair_timeout: fetch %0d not completed, required completion", i);
      end else if (i > 0 && c - prev != 3) begin
        fails++; $display("FAIL fair_gap: gap=%0d cycles, required 3", c - prev);
      end
      prev = c;
    end
    @(posedge CLK); #1;
    iREN = '0;
    repeat (3) @(posedge CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL fair_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_starve();
    int unsigned c;
    bit ok;
    do_reset();
    daddr = 32'h300; iaddr[0] = 32'h40;
    dREN = 1'b1; iREN = 2'b01;
    for (int r = 0; r < 2; r++) begin
      repeat (4) exp_q.push_back(mk_ev(2'd2, 32'h300, pat(32'h300), 1'b0));
      exp_q.push_back(mk_ev(2'd0, 32'h40, pat(32'h40), 1'b0));
    end
    for (int i = 0; i < 10; i++) begin
      wait_done(20, c, ok);
      tests_run++;
      if (!ok) begin
        fails++; $display("FAIL starve_timeout: completion %0d missing, required completion", i);
      end
    end
    @(posedge CLK); #1;
    dREN = 1'b0; iREN = '0;
    repeat (3) @(posedge CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL starve_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_lock();
    int unsigned c0, c1;
    bit ok;
    do_reset();
    iaddr[0] = 32'h10; iaddr[1] = 32'h20;
    iREN = 2'b11;
    dWEN = 1'b1; dlock = 1'b1; daddr = 32'h200; dstore = 32'hDEAD;
    exp_q.push_back(mk_ev(2'd2, 32'h200, 32'hDEAD, 1'b1));
    exp_q.push_back(mk_ev(2'd2, 32'h204, 32'hBEEF, 1'b1));
    wait_done(20, c0, ok);
    tests_run++;
    if (!ok || ramWEN !== 1'b1 || ramREN !== 1'b0) begin
      fails++; $display("FAIL lock_first: done=%0b ramWEN=%b ramREN=%b, required 1 1 0", ok, ramWEN, ramREN);
    end
    @(posedge CLK); #1;
    daddr = 32'h204; dstore = 32'hBEEF; dlock = 1'b0;
    wait_done(20, c1, ok);
    tests_run++;
    if (!ok || c1 - c0 != 2) begin
      fails++; $display("FAIL lock_gap: done=%0b gap=%0d, required 1 2", ok, c1 - c0);
    end
    @(posedge CLK); #1;
    tests_run++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
      fails++; $display("FAIL lock_release_idle: ramREN=%b ramWEN=%b, required 0 0", ramREN, ramWEN);
    end
    dWEN = 1'b0; iREN = '0;
    repeat (3) @(posedge CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL lock_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_withdraw();
    int unsigned c;
    bit ok;
    do_reset();
    iaddr[0] = 32'h10; iaddr[1] = 32'h20;
    iREN = 2'b01;
    exp_q.push_back(mk_ev(2'd0, 32'h10, pat(32'h10), 1'b0));
    wait_done(20, c, ok);
    @(posedge CLK); #1;
    iREN = '0;
    @(posedge CLK); #1;
    ram_lat = 8;
    iREN = 2'b10;
    @(posedge CLK); #1;
    tests_run++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h20) begin
      fails++; $display("FAIL withdraw_grant: ramREN=%b ramaddr=%h, required 1 00000020", ramREN, ramaddr);
    end
    @(posedge CLK); #1;
    iREN = '0;
    @(posedge CLK); #1;
    tests_run++;
    if (ramREN !== 1'b0 || iwait !== 2'b11) begin
      fails++; $display("FAIL withdraw_drop: ramREN=%b iwait=%b, required 0 11", ramREN, iwait);
    end
    ram_lat = 2;
    iREN = 2'b11;
    exp_q.push_back(mk_ev(2'd1, 32'h20, pat(32'h20), 1'b0));
    exp_q.push_back(mk_ev(2'd0, 32'h10, pat(32'h10), 1'b0));
    for (int i = 0; i < 2; i++) begin
      wait_done(20, c, ok);
      tests_run++;
      if (!ok) begin
        fails++; $display("FAIL withdraw_timeout: fetch %0d missing, required completion", i);
      end
    end
    @(posedge CLK); #1;
    iREN = '0;
    repeat (3) @(posedge CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL withdraw_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_error();
    do_reset();
    ram_lat = 1;
    err_n = 3;
    err_tag++;
    daddr = 32'h50;
    dREN = 1'b1;
    exp_q.push_back(mk_ev(2'd2, 32'h50, pat(32'h50), 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      tests_run++;
      if (dwait !== 1'b1 || ramREN !== 1'b1) begin
        fails++; $display("FAIL error_hold%0d: dwait=%b ramREN=%b, required 1 1", i, dwait, ramREN);
      end
    end
    @(posedge CLK); #1;
    tests_run++;
    if (dwait !== 1'b0 || dload !== pat(32'h50)) begin
      fails++; $display("FAIL error_complete: dwait=%b dload=%h, required 0 %h", dwait, dload, pat(32'h50));
    end
    @(posedge CLK); #1;
    dREN = 1'b0;
    tests_run++;
    if (dwait !== 1'b1) begin
      fails++; $display("FAIL error_single_pulse: dwait=%b, required 1", dwait);
    end
    repeat (2) @(posedge CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL error_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_conflict();
    do_reset();
    dREN = 1'b1; dWEN = 1'b1;
    daddr = 32'h208; dstore = 32'h1234_5678;
    exp_q.push_back(mk_ev(2'd2, 32'h208, 32'h1234_5678, 1'b1));
    @(posedge CLK); #1;
    tests_run++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234_5678 || ramaddr !== 32'h208) begin
      fails++; $display("FAIL conflict_strobes: ramWEN=%b ramREN=%b ramstore=%h ramaddr=%h, required 1 0 12345678 00000208",
                        ramWEN, ramREN, ramstore, ramaddr);
    end
    tests_run++;
    if (iload !== '0 || iwait !== 2'b11) begin
      fails++; $display("FAIL conflict_ungranted: iload=%h iwait=%b, required 0 11", iload, iwait);
    end
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    dREN = 1'b0; dWEN = 1'b0;
    repeat (2) @(posedge CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL conflict_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_starve();
    test_lock();
    test_withdraw();
    test_error();
    test_conflict();
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
